// File: rtl/raster_timing.sv
// raster_timing: one chained fine/coarse/line/frame counter with registered syncs, active and frame-start pulse.
// Optional build macro RASTER_HALF_FRAME_RATE_EN: raw_frame_counter advances on every second frame only.
module raster_timing #(
  parameter int X_FINE_PERIOD      = 100,
  parameter int X_COARSE_BITS      = 3,
  parameter int Y_STEPS            = 525,
  parameter int Y_SAT_BITS         = 9,
  parameter int FRAME_COUNTER_BITS = 14,
  parameter int H_ACTIVE           = 640,
  parameter int H_SYNC_START       = 656,
  parameter int H_SYNC_END         = 752,
  parameter int V_ACTIVE           = 480,
  parameter int V_SYNC_START       = 490,
  parameter int V_SYNC_END         = 492
) (
  input  logic                              clk,
  input  logic                              reset,
  output logic                              enable,
  output logic [$clog2(X_FINE_PERIOD)-1:0]  x_fine,
  output logic [X_COARSE_BITS-1:0]          x_coarse,
  output logic [Y_SAT_BITS-1:0]             y_sat,
  output logic [Y_SAT_BITS-1:0]             y_wrap,
  output logic [FRAME_COUNTER_BITS-1:0]     raw_frame_counter,
  output logic                              hsync,
  output logic                              vsync,
  output logic                              active,
  output logic                              new_frame
);

  localparam int XF_W     = $clog2(X_FINE_PERIOD);
  localparam int LINE_LEN = X_FINE_PERIOD << X_COARSE_BITS;
  localparam int H_W      = $clog2(LINE_LEN);
  localparam int Y_W      = ($clog2(Y_STEPS) > Y_SAT_BITS) ? $clog2(Y_STEPS) : Y_SAT_BITS;

  localparam logic [XF_W-1:0] XF_MAX    = XF_W'(X_FINE_PERIOD - 1);
  localparam logic [H_W-1:0]  HA        = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]  HSS       = H_W'(H_SYNC_START);
  localparam logic [H_W-1:0]  HSE       = H_W'(H_SYNC_END);
  localparam logic [Y_W-1:0]  Y_MAX     = Y_W'(Y_STEPS - 1);
  localparam logic [Y_W-1:0]  VA        = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0]  VSS       = Y_W'(V_SYNC_START);
  localparam logic [Y_W-1:0]  VSE       = Y_W'(V_SYNC_END);
  localparam logic [Y_W-1:0]  Y_SAT_MAX = Y_W'((1 << Y_SAT_BITS) - 1);

  logic                          r_enable;
  logic [XF_W-1:0]               r_x_fine;
  logic [X_COARSE_BITS-1:0]      r_x_coarse;
  logic [H_W-1:0]                r_h;
  logic [Y_W-1:0]                r_y;
  logic [Y_SAT_BITS-1:0]         r_y_sat;
  logic [Y_SAT_BITS-1:0]         r_y_wrap;
  logic [FRAME_COUNTER_BITS-1:0] r_frame;
  logic                          r_hsync;
  logic                          r_vsync;
  logic                          r_active;
  logic                          r_new_frame;

  logic                          w_fine_wrap;
  logic                          w_line_end;
  logic                          w_frame_end;
  logic                          w_frame_inc;
  logic [XF_W-1:0]               w_x_fine_nxt;
  logic [X_COARSE_BITS-1:0]      w_x_coarse_nxt;
  logic [H_W-1:0]                w_h_nxt;
  logic [Y_W-1:0]                w_y_nxt;
  logic [Y_SAT_BITS-1:0]         w_y_sat_nxt;

`ifdef RASTER_HALF_FRAME_RATE_EN
  logic                          r_parity;
`endif

  // All registered outputs are computed from the next counter value so they line up with the counters.
  always_comb begin
    w_fine_wrap    = (r_x_fine == XF_MAX);
    w_line_end     = w_fine_wrap && (&r_x_coarse);
    w_frame_end    = w_line_end && (r_y == Y_MAX);
    w_x_fine_nxt   = w_fine_wrap ? '0 : r_x_fine + 1'b1;
    w_x_coarse_nxt = w_fine_wrap ? r_x_coarse + 1'b1 : r_x_coarse;
    w_h_nxt        = w_line_end ? '0 : r_h + 1'b1;
    w_y_nxt        = r_y;
    if (w_line_end) begin
      w_y_nxt = w_frame_end ? '0 : r_y + 1'b1;
    end
    w_y_sat_nxt    = (w_y_nxt > Y_SAT_MAX) ? '1 : w_y_nxt[Y_SAT_BITS-1:0];
`ifdef RASTER_HALF_FRAME_RATE_EN
    w_frame_inc    = w_frame_end && r_parity;
`else
    w_frame_inc    = w_frame_end;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable    <= 1'b0;
      r_x_fine    <= '0;
      r_x_coarse  <= '0;
      r_h         <= '0;
      r_y         <= '0;
      r_y_sat     <= '0;
      r_y_wrap    <= '0;
      r_frame     <= '0;
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
      r_active    <= 1'b1;
      r_new_frame <= 1'b0;
    end else begin
      r_enable    <= ~r_enable;
      r_x_fine    <= w_x_fine_nxt;
      r_x_coarse  <= w_x_coarse_nxt;
      r_h         <= w_h_nxt;
      r_y         <= w_y_nxt;
      r_y_sat     <= w_y_sat_nxt;
      r_y_wrap    <= w_y_nxt[Y_SAT_BITS-1:0];
      r_hsync     <= !((w_h_nxt >= HSS) && (w_h_nxt < HSE));
      r_vsync     <= !((w_y_nxt >= VSS) && (w_y_nxt < VSE));
      r_active    <= (w_h_nxt < HA) && (w_y_nxt < VA);
      r_new_frame <= w_frame_end;
      if (w_frame_inc) begin
        r_frame <= r_frame + 1'b1;
      end
    end
  end

`ifdef RASTER_HALF_FRAME_RATE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_frame_end) begin
      r_parity <= ~r_parity;
    end
  end
`endif

  assign enable            = r_enable;
  assign x_fine            = r_x_fine;
  assign x_coarse          = r_x_coarse;
  assign y_sat             = r_y_sat;
  assign y_wrap            = r_y_wrap;
  assign raw_frame_counter = r_frame;
  assign hsync             = r_hsync;
  assign vsync             = r_vsync;
  assign active            = r_active;
  assign new_frame         = r_new_frame;

endmodule

// File: tb/tb_raster_timing.sv
// Bench for raster_timing: a default-size instance for line timing and a shrunken instance for whole frames,
// both checked every cycle against a closed-form model derived from the elapsed clock count.
module tb_raster_timing;

  localparam int S_FINE = 10;
  localparam int S_CB   = 2;
  localparam int S_YS   = 20;
  localparam int S_SAT  = 4;
  localparam int S_FCB  = 4;
  localparam int S_HA   = 24;
  localparam int S_HSS  = 28;
  localparam int S_HSE  = 34;
  localparam int S_VA   = 12;
  localparam int S_VSS  = 14;
  localparam int S_VSE  = 16;
  localparam int S_FRAME = (S_FINE << S_CB) * S_YS;

  typedef struct packed {
    logic        en;
    logic [15:0] xf;
    logic [15:0] xc;
    logic [15:0] ysat;
    logic [15:0] ywrap;
    logic [15:0] fc;
    logic        hs;
    logic        vs;
    logic        act;
    logic        nf;
  } snap_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  longint t = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // default-parameter instance
  logic       d_enable, d_hsync, d_vsync, d_active, d_new_frame;
  logic [6:0] d_x_fine;
  logic [2:0] d_x_coarse;
  logic [8:0] d_y_sat, d_y_wrap;
  logic [13:0] d_frame;

  raster_timing u_dut_def (
    .clk(clk), .reset(reset), .enable(d_enable), .x_fine(d_x_fine), .x_coarse(d_x_coarse),
    .y_sat(d_y_sat), .y_wrap(d_y_wrap), .raw_frame_counter(d_frame),
    .hsync(d_hsync), .vsync(d_vsync), .active(d_active), .new_frame(d_new_frame)
  );

  // shrunken instance: 40-clock lines, 20 lines, 800-clock frames
  logic       s_enable, s_hsync, s_vsync, s_active, s_new_frame;
  logic [3:0] s_x_fine;
  logic [1:0] s_x_coarse;
  logic [3:0] s_y_sat, s_y_wrap;
  logic [3:0] s_frame;

  raster_timing #(
    .X_FINE_PERIOD(S_FINE), .X_COARSE_BITS(S_CB), .Y_STEPS(S_YS), .Y_SAT_BITS(S_SAT),
    .FRAME_COUNTER_BITS(S_FCB), .H_ACTIVE(S_HA), .H_SYNC_START(S_HSS), .H_SYNC_END(S_HSE),
    .V_ACTIVE(S_VA), .V_SYNC_START(S_VSS), .V_SYNC_END(S_VSE)
  ) u_dut_small (
    .clk(clk), .reset(reset), .enable(s_enable), .x_fine(s_x_fine), .x_coarse(s_x_coarse),
    .y_sat(s_y_sat), .y_wrap(s_y_wrap), .raw_frame_counter(s_frame),
    .hsync(s_hsync), .vsync(s_vsync), .active(s_active), .new_frame(s_new_frame)
  );

  snap_t d_obs, s_obs;
  assign d_obs = '{en: d_enable, xf: 16'(d_x_fine), xc: 16'(d_x_coarse), ysat: 16'(d_y_sat),
                   ywrap: 16'(d_y_wrap), fc: 16'(d_frame), hs: d_hsync, vs: d_vsync,
                   act: d_active, nf: d_new_frame};
  assign s_obs = '{en: s_enable, xf: 16'(s_x_fine), xc: 16'(s_x_coarse), ysat: 16'(s_y_sat),
                   ywrap: 16'(s_y_wrap), fc: 16'(s_frame), hs: s_hsync, vs: s_vsync,
                   act: s_active, nf: s_new_frame};

  // Expected outputs after t clocks since reset release, from plain division/modulo on the raster geometry.
  function automatic snap_t model(input longint tt, input int fine, input int cb, input int ysteps,
                                  input int satb, input int fcb, input int ha, input int hss,
                                  input int hse, input int va, input int vss, input int vse);
    snap_t s;
    longint line_len, frame_len, h, y, frames, fc, sat_max;
    line_len  = longint'(fine) * (longint'(1) << cb);
    frame_len = line_len * ysteps;
    h         = tt % line_len;
    y         = (tt / line_len) % ysteps;
    frames    = tt / frame_len;
    fc        = frames;
`ifdef RASTER_HALF_FRAME_RATE_EN
    fc        = frames / 2;
`endif
    sat_max   = (longint'(1) << satb) - 1;
    s.en      = (tt % 2) == 1;
    s.xf      = 16'(h % fine);
    s.xc      = 16'(h / fine);
    s.ysat    = 16'((y > sat_max) ? sat_max : y);
    s.ywrap   = 16'(y % (sat_max + 1));
    s.fc      = 16'(fc % (longint'(1) << fcb));
    s.hs      = !(h >= hss && h < hse);
    s.vs      = !(y >= vss && y < vse);
    s.act     = (h < ha) && (y < va);
    s.nf      = (tt > 0) && (tt % frame_len == 0);
    return s;
  endfunction

  function automatic snap_t exp_def(input longint tt);
    return model(tt, 100, 3, 525, 9, 14, 640, 656, 752, 480, 490, 492);
  endfunction

  function automatic snap_t exp_small(input longint tt);
    return model(tt, S_FINE, S_CB, S_YS, S_SAT, S_FCB, S_HA, S_HSS, S_HSE, S_VA, S_VSS, S_VSE);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) t = 0;
    else t = t + 1;
    #1;
  endtask

  task automatic test_reset();
    snap_t e;
    reset = 1'b1;
    repeat (4) tick();
    reset = 1'b0;
    e = exp_def(0);
    n_checks++;
    if (d_obs !== e) begin
      n_errors++;
      $display("FAIL reset_def got=%p exp=%p", d_obs, e);
    end
    e = exp_small(0);
    n_checks++;
    if (s_obs !== e) begin
      n_errors++;
      $display("FAIL reset_small got=%p exp=%p", s_obs, e);
    end
    n_checks++;
    if ({s_hsync, s_vsync, s_active, s_new_frame} !== 4'b1110) begin
      n_errors++;
      $display("FAIL reset_flags got=%b exp=1110", {s_hsync, s_vsync, s_active, s_new_frame});
    end
  endtask

  task automatic test_line();
    snap_t e;
    int hs_low = 0;
    int hs_first = -1;
    int act_cnt = 0;
    for (int i = 1; i < 1600; i++) begin
      tick();
      e = exp_def(t);
      n_checks++;
      if (d_obs !== e) begin
        n_errors++;
        $display("FAIL line_def t=%0d got=%p exp=%p", t, d_obs, e);
      end
      e = exp_small(t);
      n_checks++;
      if (s_obs !== e) begin
        n_errors++;
        $display("FAIL line_small t=%0d got=%p exp=%p", t, s_obs, e);
      end
      if (t >= 800) begin
        if (d_hsync == 1'b0) begin
          if (hs_first < 0) hs_first = int'(t - 800);
          hs_low++;
        end
        if (d_active == 1'b1) act_cnt++;
      end
      if (t == 800) begin
        n_checks++;
        if (d_y_wrap !== 9'd1 || d_x_fine !== 7'd0 || d_x_coarse !== 3'd0) begin
          n_errors++;
          $display("FAIL line_end_y got y=%0d xf=%0d xc=%0d exp y=1 xf=0 xc=0", d_y_wrap, d_x_fine, d_x_coarse);
        end
      end
    end
    n_checks++;
    if (hs_low != 96) begin
      n_errors++;
      $display("FAIL hsync_width got=%0d exp=96", hs_low);
    end
    n_checks++;
    if (hs_first != 656) begin
      n_errors++;
      $display("FAIL hsync_start got=%0d exp=656", hs_first);
    end
    n_checks++;
    if (act_cnt != 640) begin
      n_errors++;
      $display("FAIL active_width got=%0d exp=640", act_cnt);
    end
  endtask

  task automatic test_frames();
    snap_t e;
    int n_frames;
    int pulses = 0;
    int vs_low = 0;
    int sat_cnt = 0;
    int wraps = 0;
    logic [3:0] prev_fc;
`ifdef RASTER_HALF_FRAME_RATE_EN
    n_frames = 33;
`else
    n_frames = 17;
`endif
    prev_fc = s_frame;
    for (int i = 0; i < n_frames * S_FRAME; i++) begin
      tick();
      e = exp_small(t);
      n_checks++;
      if (s_obs !== e) begin
        n_errors++;
        $display("FAIL frame_small t=%0d got=%p exp=%p", t, s_obs, e);
      end
      e = exp_def(t);
      n_checks++;
      if (d_obs !== e) begin
        n_errors++;
        $display("FAIL frame_def t=%0d got=%p exp=%p", t, d_obs, e);
      end
      if (s_new_frame) pulses++;
      if (!s_vsync) vs_low++;
      if (s_y_sat == 4'd15) sat_cnt++;
      if (s_new_frame && s_frame == 4'd0 && prev_fc == 4'd15) wraps++;
      prev_fc = s_frame;
    end
    n_checks++;
    if (pulses != n_frames) begin
      n_errors++;
      $display("FAIL frame_pulses got=%0d exp=%0d", pulses, n_frames);
    end
    n_checks++;
    if (vs_low != n_frames * 80) begin
      n_errors++;
      $display("FAIL vsync_width got=%0d exp=%0d", vs_low, n_frames * 80);
    end
    n_checks++;
    if (sat_cnt != n_frames * 200) begin
      n_errors++;
      $display("FAIL y_sat_hold got=%0d exp=%0d", sat_cnt, n_frames * 200);
    end
    n_checks++;
    if (wraps != 1) begin
      n_errors++;
      $display("FAIL frame_wrap got=%0d exp=1", wraps);
    end
  endtask

  task automatic test_mid_reset();
    snap_t e;
    int run_len;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      run_len = (k == 0) ? 420 : int'($urandom_range(1, 1500));
      for (int i = 0; i < run_len; i++) begin
        tick();
        e = exp_small(t);
        n_checks++;
        if (s_obs !== e) begin
          n_errors++;
          $display("FAIL run_small t=%0d got=%p exp=%p", t, s_obs, e);
        end
      end
      reset = 1'b1;
      repeat ((k == 3) ? int'($urandom_range(2, 4)) : 1) tick();
      reset = 1'b0;
      e = exp_small(0);
      n_checks++;
      if (s_obs !== e) begin
        n_errors++;
        $display("FAIL abort_small k=%0d got=%p exp=%p", k, s_obs, e);
      end
      e = exp_def(0);
      n_checks++;
      if (d_obs !== e) begin
        n_errors++;
        $display("FAIL abort_def k=%0d got=%p exp=%p", k, d_obs, e);
      end
      tick();
      n_checks++;
      if (s_x_fine !== 4'd1 || s_new_frame !== 1'b0 || d_x_fine !== 7'd1) begin
        n_errors++;
        $display("FAIL post_reset_h k=%0d got xf=%0d nf=%0d dxf=%0d exp xf=1 nf=0 dxf=1",
                 k, s_x_fine, s_new_frame, d_x_fine);
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frames();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
